// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Drives a 4-digit common-anode multiplexed 7-segment display from the four
// BCD stopwatch digits. The digits are captured into shadow registers once
// per display frame, so a frame never mixes old and new time values. Each
// digit slot starts with a short all-anodes-off guard to avoid ghosting.
// Leading zeros can optionally be suppressed. Decimal points are placed to
// read M.SS.T.
//
// Parameters:
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  all-off cycles at the start of each slot (< REFRESH_DIV)
//   ACTIVE_LOW    1 = seg/dp/an are active-low, 0 = active-high
//
// Ports:
//   clk, reset       system clock; synchronous active-high reset
//   Minutes          BCD minutes digit            (shown on an[3])
//   Tens_Seconds     BCD tens-of-seconds digit    (shown on an[2])
//   Ones_Seconds     BCD seconds digit            (shown on an[1])
//   Tenths_Seconds   BCD tenths digit             (shown on an[0])
//   enable           1 = display lit; 0 = dark (scanning continues)
//   blank_lead       1 = suppress leading zeros on digits 3 and 2 (live)
//   seg[6:0]         segments {g,f,e,d,c,b,a}
//   dp               decimal point of the active digit
//   an[3:0]          anode selects, an[0] = rightmost digit
//   frame_done       one-cycle pulse when the shadow registers load
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 4,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Minutes,
   input  logic [3:0] Tens_Seconds,
   input  logic [3:0] Ones_Seconds,
   input  logic [3:0] Tenths_Seconds,
   input  logic       enable,
   input  logic       blank_lead,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_done
);

   localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

   // Polarity mask: XOR with an active-high value gives the pin level.
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
   localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
   localparam logic       DP_POL  = ACTIVE_LOW;

   logic [PW-1:0] p_reg, p_next;
   logic [1:0]    i_reg, i_next;
   logic [3:0]    shadow_reg [4];
   logic [3:0]    digit_in   [4];

   logic [6:0] seg_reg, seg_next;
   logic       dp_reg, dp_next;
   logic [3:0] an_reg, an_next;
   logic       frame_done_reg;

   logic       wrap;
   logic       load;
   logic [3:0] cur_digit;
   logic       lead_blank;
   logic       in_guard;
   logic       lit;

   // Slot index order: 0 = Tenths (rightmost) ... 3 = Minutes.
   assign digit_in[0] = Tenths_Seconds;
   assign digit_in[1] = Ones_Seconds;
   assign digit_in[2] = Tens_Seconds;
   assign digit_in[3] = Minutes;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;   // non-BCD shows a dash
      endcase
      return s;
   endfunction

   always_comb begin
      wrap      = (p_reg == P_LAST);
      // Loading on the last edge of slot 3 makes the new values appear
      // exactly at the start of the next slot 0.
      load      = wrap && (i_reg == 2'd3);
      p_next    = wrap ? '0 : p_reg + 1'b1;
      i_next    = wrap ? i_reg + 2'd1 : i_reg;
      cur_digit = shadow_reg[i_reg];

      // Digit 2 is only a leading zero when minutes are zero as well.
      lead_blank = blank_lead &&
                   (((i_reg == 2'd3) && (shadow_reg[3] == 4'd0)) ||
                    ((i_reg == 2'd2) && (shadow_reg[3] == 4'd0) &&
                     (shadow_reg[2] == 4'd0)));
      in_guard   = (32'(p_reg) < BLANK_CYCLES);
      lit        = enable && !lead_blank && !in_guard;

      // Active-high view; polarity is applied at the output register.
      seg_next = lit ? decode(cur_digit) : 7'h00;
      dp_next  = lit && i_reg[0];          // dp after Minutes and Ones
      an_next  = lit ? (4'b0001 << i_reg) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_reg          <= '0;
         i_reg          <= 2'd0;
         frame_done_reg <= 1'b0;
         seg_reg        <= SEG_POL;
         dp_reg         <= DP_POL;
         an_reg         <= AN_POL;
      end else begin
         p_reg          <= p_next;
         i_reg          <= i_next;
         frame_done_reg <= load;
         seg_reg        <= seg_next ^ SEG_POL;
         dp_reg         <= dp_next ^ DP_POL;
         an_reg         <= an_next ^ AN_POL;
      end
   end

   always_ff @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (reset) begin
            shadow_reg[d] <= 4'd0;
         end else if (load) begin
            shadow_reg[d] <= digit_in[d];
         end
      end
   end

   assign seg        = seg_reg;
   assign dp         = dp_reg;
   assign an         = an_reg;
   assign frame_done = frame_done_reg;

endmodule
